ifu_axi_fetch: RTL and testbench



---
 rtl/ifu_axi_fetch.sv | 102 ++++++++++
 tb/tb_ifu_axi_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_fetch.sv
// rtl/ifu_axi_fetch.sv - instruction fetch unit: owns the PC, fetches over single-beat AXI4 read
module ifu_axi_fetch #(
    parameter logic [31:0] RESET_PC = 32'h2000_0000,
    parameter logic [3:0]  FETCH_ID = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic [31:0] next_pc,
    output logic [31:0] perf_fetch_cnt
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc;
    logic        ar_hs, r_hs, commit, r_bad;

    assign ar_hs  = (state_q == ADDR) && io_master_arready;
    assign r_hs   = (state_q == DATA) && io_master_rvalid;
    assign commit = (state_q == HOLD) && inst_ready;
    assign r_bad  = (io_master_rresp != 2'b00) || (io_master_rid != FETCH_ID) || !io_master_rlast;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = (pc[1:0] != 2'b00) ? HOLD : ADDR;
            ADDR: if (ar_hs) state_d = DATA;
            DATA: if (r_hs) state_d = HOLD;
            HOLD: if (commit) state_d = (next_pc[1:0] != 2'b00) ? HOLD : ADDR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_master_arvalid = (state_q == ADDR);
        io_master_rready  = (state_q == DATA);
        inst_valid        = (state_q == HOLD);
        io_master_araddr  = pc;
        io_master_arid    = FETCH_ID;
        io_master_arlen   = 8'd0;
        io_master_arsize  = 3'b010;
        io_master_arburst = 2'b01;
    end

    // Misaligned PCs bypass the bus and become a fault entry directly in HOLD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_pc    <= RESET_PC;
            inst_fault <= 1'b0;
        end else begin
            if (state_q == IDLE && pc[1:0] != 2'b00) begin
                inst       <= 32'h0;
                inst_pc    <= pc;
                inst_fault <= 1'b1;
            end
            if (r_hs) begin
                inst       <= io_master_rdata;
                inst_pc    <= pc;
                inst_fault <= r_bad;
            end
            if (commit) begin
                pc <= next_pc;
                if (next_pc[1:0] != 2'b00) begin
                    inst       <= 32'h0;
                    inst_pc    <= next_pc;
                    inst_fault <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      perf_fetch_cnt <= 32'h0;
        else if (commit) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// tb/tb_ifu_axi_fetch.sv - directed self-checking bench for ifu_axi_fetch
module tb_ifu_axi_fetch;

    logic        clock, reset;
    logic        arready, arvalid, rvalid, rready, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst, inst_pc, next_pc, perf_fetch_cnt;

    int checks = 0;
    int errors = 0;

    ifu_axi_fetch dut (
        .clock(clock), .reset(reset),
        .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst), .io_master_rvalid(rvalid), .io_master_rready(rready),
        .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast),
        .io_master_rid(rid), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault), .next_pc(next_pc),
        .perf_fetch_cnt(perf_fetch_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Entered at a negedge with the DUT in ADDR; leaves it in HOLD with the entry checked.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input logic [3:0] id, input logic last, input logic exp_fault);
        check("f_arvalid", {31'b0, arvalid}, 32'd1);
        check("f_araddr", araddr, addr);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("f_rready", {31'b0, rready}, 32'd1);
        rvalid = 1'b1; rdata = data; rresp = resp; rid = id; rlast = last;
        tick();
        rvalid = 1'b0; rresp = 2'b00; rid = 4'h0; rlast = 1'b1;
        check("f_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("f_inst", inst, data);
        check("f_inst_pc", inst_pc, addr);
        check("f_inst_fault", {31'b0, inst_fault}, {31'b0, exp_fault});
    endtask

    task automatic commit(input logic [31:0] npc);
        inst_ready = 1'b1; next_pc = npc;
        tick();
        inst_ready = 1'b0; next_pc = 32'hxxxx_xxxx;
    endtask

    initial begin
        reset = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        rlast = 1'b1; rid = 4'h0; inst_ready = 1'b0; next_pc = 32'h0;
        tick(); tick();
        check("rst_arvalid", {31'b0, arvalid}, 32'd0);
        check("rst_rready", {31'b0, rready}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h2000_0000);
        check("rst_fault", {31'b0, inst_fault}, 32'd0);
        check("rst_cnt", perf_fetch_cnt, 32'h0);
        check("rst_ar_const", {16'b0, arid, arlen, arsize, arburst}, {16'b0, 4'h0, 8'h00, 3'b010, 2'b01});

        // Release: one cycle of IDLE, then ADDR at RESET_PC.
        reset = 1'b1;
        check("idle_arvalid", {31'b0, arvalid}, 32'd0);
        tick();
        fetch(32'h2000_0000, 32'h0000_0013, 2'b00, 4'h0, 1'b1, 1'b0);
        commit(32'h2000_0004);
        check("t1_arvalid", {31'b0, arvalid}, 32'd1);
        check("t1_araddr", araddr, 32'h2000_0004);
        check("t1_cnt", perf_fetch_cnt, 32'd1);
        check("t1_inst_valid", {31'b0, inst_valid}, 32'd0);

        // arready low for 5 cycles, then rvalid late by 3 cycles.
        for (int i = 0; i < 6; i++) begin
            check("t2_arvalid", {31'b0, arvalid}, 32'd1);
            check("t2_araddr", araddr, 32'h2000_0004);
            check("t2_rready_lo", {31'b0, rready}, 32'd0);
            arready = (i == 5);
            tick();
        end
        arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_rready", {31'b0, rready}, 32'd1);
            check("t2_arvalid_lo", {31'b0, arvalid}, 32'd0);
            check("t2_inst_valid_lo", {31'b0, inst_valid}, 32'd0);
            rvalid = (i == 3); rdata = 32'h0010_0093;
            tick();
        end
        rvalid = 1'b0;
        check("t2_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t2_inst", inst, 32'h0010_0093);
        check("t2_inst_pc", inst_pc, 32'h2000_0004);

        // Core stalls for 10 cycles in HOLD.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_inst_valid", {31'b0, inst_valid}, 32'd1);
            check("t5_inst", inst, 32'h0010_0093);
            check("t5_inst_pc", inst_pc, 32'h2000_0004);
            check("t5_arvalid", {31'b0, arvalid}, 32'd0);
            check("t5_cnt", perf_fetch_cnt, 32'd1);
        end
        commit(32'h2000_0008);
        check("t5_cnt_after", perf_fetch_cnt, 32'd2);

        // Faulting responses: SLVERR, wrong ID, missing rlast; then a clean one.
        fetch(32'h2000_0008, 32'hDEAD_BEEF, 2'b10, 4'h0, 1'b1, 1'b1);
        commit(32'h2000_000C);
        fetch(32'h2000_000C, 32'h0000_0013, 2'b00, 4'h3, 1'b1, 1'b1);
        commit(32'h2000_0010);
        fetch(32'h2000_0010, 32'h0000_0013, 2'b00, 4'h0, 1'b0, 1'b1);
        commit(32'h2000_0014);
        fetch(32'h2000_0014, 32'h0020_0113, 2'b00, 4'h0, 1'b1, 1'b0);

        // Misaligned next_pc: fault entries without any AR.
        commit(32'h2000_0006);
        check("t4_arvalid", {31'b0, arvalid}, 32'd0);
        check("t4_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t4_fault", {31'b0, inst_fault}, 32'd1);
        check("t4_inst", inst, 32'h0);
        check("t4_inst_pc", inst_pc, 32'h2000_0006);
        check("t4_cnt", perf_fetch_cnt, 32'd6);
        commit(32'h2000_0003);
        check("t4b_arvalid", {31'b0, arvalid}, 32'd0);
        check("t4b_inst_pc", inst_pc, 32'h2000_0003);
        check("t4b_fault", {31'b0, inst_fault}, 32'd1);
        commit(32'h2000_0100);
        check("t4_resume_araddr", araddr, 32'h2000_0100);
        check("t4_resume_cnt", perf_fetch_cnt, 32'd8);

        // Async reset while in DATA.
        check("t6_arvalid", {31'b0, arvalid}, 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("t6_in_data", {31'b0, rready}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rready", {31'b0, rready}, 32'd0);
        check("t6_arvalid_rst", {31'b0, arvalid}, 32'd0);
        check("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("t6_inst_pc", inst_pc, 32'h2000_0000);
        check("t6_araddr", araddr, 32'h2000_0000);
        check("t6_cnt", perf_fetch_cnt, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        fetch(32'h2000_0000, 32'h0000_0013, 2'b00, 4'h0, 1'b1, 1'b0);

        // Counter wrap.
        force dut.perf_fetch_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.perf_fetch_cnt;
        tick();
        check("t7_cnt_forced", perf_fetch_cnt, 32'hFFFF_FFFF);
        commit(32'h2000_0004);
        check("t7_cnt_wrap", perf_fetch_cnt, 32'h0);
        check("t7_araddr", araddr, 32'h2000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
